psg_write_scheduler: RTL and testbench

Serialises SN76489-style PSG register writes from NREQ independent requesters, such as the music sequencer and the CPU-side register port, onto the single PSG write bus (nCE, nWE, D, READY).
It expands logical register writes into the PSG byte protocol:
- tone writes become a latch byte followed by a data byte;
- volume and noise writes are a single latch byte.
It also generates the PSG clock-enable pulse from the 100 MHz system clock and sits between the requesters and ti_top.

---
 rtl/psg_write_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_psg_write_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_write_scheduler.sv
// Arbitrates PSG register writes from several requesters and serialises them onto the
// SN76489-style byte bus, with a free-running clock-enable divider and READY timeout.
module psg_write_scheduler #(
    parameter int NREQ    = 2,
    parameter int CLK_DIV = 28,
    parameter int TIMEOUT = 4096
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    reg_sel,
    input  logic [10*NREQ-1:0]   reg_data,
    output logic [NREQ-1:0]      ack,
    output logic                 psg_clk,
    output logic                 nCE,
    output logic                 nWE,
    output logic [7:0]           D,
    input  logic                 READY,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SETUP,
        S_ASSERT,
        S_WAITRDY,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   div_reg;
    logic [PW-1:0]   ptr_reg, ptr_next;
    logic [PW-1:0]   win_reg, win_next;
    logic [2:0]      sel_reg, sel_next;
    logic [9:0]      data_reg, data_next;
    logic [7:0]      d_reg, d_next;
    logic            pend_reg, pend_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            err_reg, err_next;

    logic [2:0]      sel_arr  [NREQ];
    logic [9:0]      data_arr [NREQ];
    logic            found;
    logic [PW-1:0]   win_idx;
    logic            timeout_hit;
    int              sum;

    // Free-running divider; never touched by the FSM so the PSG clock stays periodic.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            div_reg <= '0;
        end else if (div_reg == DW'(CLK_DIV - 1)) begin
            div_reg <= '0;
        end else begin
            div_reg <= div_reg + DW'(1);
        end
    end

    assign psg_clk = (div_reg == DW'(CLK_DIV - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign sel_arr[gi]  = reg_sel[3*gi +: 3];
            assign data_arr[gi] = reg_data[10*gi +: 10];
            assign ack[gi]      = (state_reg == S_DONE) && (win_reg == PW'(gi));
        end
    endgenerate

    // Round-robin search starting at the pointer; first asserted request wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        sum     = 0;
        for (int k = 0; k < NREQ; k++) begin
            sum = int'(ptr_reg) + k;
            if (sum >= NREQ) begin
                sum = sum - NREQ;
            end
            if (!found && req[PW'(sum)]) begin
                found   = 1'b1;
                win_idx = PW'(sum);
            end
        end
    end

    assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_reg <= S_IDLE;
            ptr_reg   <= '0;
            win_reg   <= '0;
            sel_reg   <= '0;
            data_reg  <= '0;
            d_reg     <= '0;
            pend_reg  <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
            sel_reg   <= sel_next;
            data_reg  <= data_next;
            d_reg     <= d_next;
            pend_reg  <= pend_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        win_next   = win_reg;
        sel_next   = sel_reg;
        data_next  = data_reg;
        d_next     = d_reg;
        pend_next  = pend_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;

        if (err_clr) begin
            err_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    state_next = S_GRANT;
                    win_next   = win_idx;
                    ptr_next   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
                    sel_next   = sel_arr[win_idx];
                    data_next  = data_arr[win_idx];
                end
            end
            S_GRANT: begin
                // Latch byte {1, ch, type, low nibble}; tone periods on channels 0-2 need a data byte.
                d_next     = {1'b1, sel_reg, data_reg[3:0]};
                pend_next  = !sel_reg[0] && (sel_reg[2:1] != 2'b11);
                state_next = S_SETUP;
            end
            S_SETUP: begin
                if (psg_clk) begin
                    state_next = S_ASSERT;
                    cnt_next   = '0;
                end
            end
            S_ASSERT, S_WAITRDY: begin
                cnt_next = cnt_reg + CW'(1);
                if (timeout_hit) begin
                    // Abandon the rest of the write but still finish so the requester is acked.
                    state_next = S_RELEASE;
                    pend_next  = 1'b0;
                    err_next   = 1'b1;
                end else if ((state_reg == S_ASSERT) && !READY) begin
                    state_next = S_WAITRDY;
                end else if ((state_reg == S_WAITRDY) && READY) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (psg_clk) begin
                    if (pend_reg) begin
                        d_next     = {2'b00, data_reg[9:4]};
                        pend_next  = 1'b0;
                        state_next = S_SETUP;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign nCE         = !((state_reg == S_ASSERT) || (state_reg == S_WAITRDY));
    assign nWE         = nCE;
    assign D           = d_reg;
    assign busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_psg_write_scheduler.sv
// Directed bench for psg_write_scheduler: READY responder, bus/ack monitor and scenario tasks.
module tb_psg_write_scheduler;

    logic        CLK100MHZ;
    logic        CPU_RESETN;
    logic [1:0]  req;
    logic [5:0]  reg_sel;
    logic [19:0] reg_data;
    logic [1:0]  ack;
    logic        psg_clk;
    logic        nCE;
    logic        nWE;
    logic [7:0]  D;
    logic        READY;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    int n_vec  = 0;
    int n_miss = 0;

    // READY responder controls
    int rdy_delay = 3;
    int rdy_low   = 6;
    bit rdy_stuck = 1'b0;
    int strobe_cyc;

    // monitor state
    logic [7:0] byte_log [$];
    int         ack_log  [$];
    int         d_glitch = 0;
    int         low_len = 0;
    int         last_low_len = 0;
    logic [7:0] strobe_d = 8'h00;
    logic       prev_nce = 1'b1;
    int         cyc = 0;
    int         last_pulse = -1;
    int         bad_int = 0;
    int         pulse_cnt = 0;

    psg_write_scheduler #(.NREQ(2), .CLK_DIV(28), .TIMEOUT(4096)) dut (
        .CLK100MHZ   (CLK100MHZ),
        .CPU_RESETN  (CPU_RESETN),
        .req         (req),
        .reg_sel     (reg_sel),
        .reg_data    (reg_data),
        .ack         (ack),
        .psg_clk     (psg_clk),
        .nCE         (nCE),
        .nWE         (nWE),
        .D           (D),
        .READY       (READY),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial CLK100MHZ = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    always @(posedge CLK100MHZ) cyc <= cyc + 1;

    // PSG READY model: goes low rdy_delay cycles into a strobe for rdy_low cycles.
    initial begin
        READY = 1'b1;
        strobe_cyc = 0;
        forever begin
            @(posedge CLK100MHZ);
            #1;
            if (!nCE && !nWE && !rdy_stuck) begin
                strobe_cyc++;
                READY = !(strobe_cyc >= rdy_delay && strobe_cyc < rdy_delay + rdy_low);
            end else begin
                strobe_cyc = 0;
                READY = 1'b1;
            end
        end
    end

    // Bus monitor: logs strobed bytes, acks, D stability and psg_clk spacing.
    initial begin
        forever begin
            @(negedge CLK100MHZ);
            if (!nCE && prev_nce) begin
                byte_log.push_back(D);
                strobe_d = D;
                low_len = 1;
            end else if (!nCE) begin
                low_len++;
                if (D !== strobe_d) d_glitch++;
            end
            if (nCE && !prev_nce) last_low_len = low_len;
            prev_nce = nCE;
            for (int r = 0; r < 2; r++) if (ack[r]) ack_log.push_back(r);
            if (!CPU_RESETN) begin
                last_pulse = -1;
            end else if (psg_clk) begin
                pulse_cnt++;
                if (last_pulse >= 0 && (cyc - last_pulse) != 28) bad_int++;
                last_pulse = cyc;
            end
        end
    end

    function automatic logic [7:0] byte_at(input int i);
        if (i < byte_log.size()) return byte_log[i];
        return 8'hxx;
    endfunction

    function automatic int ack_at(input int i);
        if (i < ack_log.size()) return ack_log[i];
        return -1;
    endfunction

    task automatic clear_logs();
        byte_log.delete();
        ack_log.delete();
        d_glitch = 0;
    endtask

    task automatic set_req(input int r, input logic [2:0] s, input logic [9:0] d);
        reg_sel[3*r +: 3]   = s;
        reg_data[10*r +: 10] = d;
        req[r] = 1'b1;
    endtask

    task automatic wait_ack(input int r, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK100MHZ);
            if (ack[r]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        CPU_RESETN = 1'b0;
        req = '0; reg_sel = '0; reg_data = '0; err_clr = 1'b0;
        repeat (3) @(negedge CLK100MHZ);
        n_vec++; if (nCE !== 1'b1)         begin n_miss++; $display("FAIL rst_nCE got %b want 1", nCE); end
        n_vec++; if (nWE !== 1'b1)         begin n_miss++; $display("FAIL rst_nWE got %b want 1", nWE); end
        n_vec++; if (D !== 8'h00)          begin n_miss++; $display("FAIL rst_D got %h want 00", D); end
        n_vec++; if (ack !== 2'b00)        begin n_miss++; $display("FAIL rst_ack got %b want 00", ack); end
        n_vec++; if (busy !== 1'b0)        begin n_miss++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if (timeout_err !== 1'b0) begin n_miss++; $display("FAIL rst_err got %b want 0", timeout_err); end
        n_vec++; if (psg_clk !== 1'b0)     begin n_miss++; $display("FAIL rst_psg_clk got %b want 0", psg_clk); end
        $display("test_reset: outputs checked in reset");
    endtask

    task automatic test_divider();
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        repeat (26) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        n_vec++; if (psg_clk !== 1'b0) begin n_miss++; $display("FAIL div_pre got %b want 0", psg_clk); end
        @(posedge CLK100MHZ); @(negedge CLK100MHZ);
        n_vec++; if (psg_clk !== 1'b1) begin n_miss++; $display("FAIL div_first got %b want 1", psg_clk); end
        @(posedge CLK100MHZ); @(negedge CLK100MHZ);
        n_vec++; if (psg_clk !== 1'b0) begin n_miss++; $display("FAIL div_single got %b want 0", psg_clk); end
        repeat (27) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        n_vec++; if (psg_clk !== 1'b1) begin n_miss++; $display("FAIL div_second got %b want 1", psg_clk); end
        $display("test_divider: first pulse on cycle 28, second on cycle 56");
    endtask

    task automatic test_volume();
        bit ok;
        clear_logs();
        set_req(0, 3'b001, 10'h005);
        wait_ack(0, 500, ok);
        req[0] = 1'b0;
        repeat (60) @(negedge CLK100MHZ);
        n_vec++; if (!ok) begin n_miss++; $display("FAIL vol_ack got none want ack0"); end
        n_vec++; if (byte_log.size() != 1) begin n_miss++; $display("FAIL vol_nbytes got %0d want 1", byte_log.size()); end
        n_vec++; if (byte_at(0) !== 8'h95) begin n_miss++; $display("FAIL vol_byte got %h want 95", byte_at(0)); end
        n_vec++; if (ack_log.size() != 1) begin n_miss++; $display("FAIL vol_nacks got %0d want 1", ack_log.size()); end
        n_vec++; if (busy !== 1'b0) begin n_miss++; $display("FAIL vol_busy got %b want 0", busy); end
        n_vec++; if (d_glitch != 0) begin n_miss++; $display("FAIL vol_dstable got %0d changes want 0", d_glitch); end
        $display("test_volume: req0 sel=001 data=005 bytes=%0d", byte_log.size());
    endtask

    task automatic test_noise();
        bit ok;
        clear_logs();
        set_req(0, 3'b110, 10'h3F2);
        wait_ack(0, 500, ok);
        req[0] = 1'b0;
        repeat (60) @(negedge CLK100MHZ);
        n_vec++; if (!ok) begin n_miss++; $display("FAIL noise_ack got none want ack0"); end
        n_vec++; if (byte_log.size() != 1) begin n_miss++; $display("FAIL noise_nbytes got %0d want 1", byte_log.size()); end
        n_vec++; if (byte_at(0) !== 8'hE2) begin n_miss++; $display("FAIL noise_byte got %h want e2", byte_at(0)); end
        $display("test_noise: req0 sel=110 data=3f2 bytes=%0d", byte_log.size());
    endtask

    task automatic test_tone();
        bit ok;
        clear_logs();
        set_req(1, 3'b010, 10'h3A7);
        repeat (3) @(negedge CLK100MHZ);
        n_vec++; if (busy !== 1'b1) begin n_miss++; $display("FAIL tone_busy got %b want 1", busy); end
        reg_data[19:10] = 10'h000;
        reg_sel[5:3]    = 3'b111;
        wait_ack(1, 500, ok);
        req[1] = 1'b0;
        repeat (60) @(negedge CLK100MHZ);
        n_vec++; if (!ok) begin n_miss++; $display("FAIL tone_ack got none want ack1"); end
        n_vec++; if (byte_log.size() != 2) begin n_miss++; $display("FAIL tone_nbytes got %0d want 2", byte_log.size()); end
        n_vec++; if (byte_at(0) !== 8'hA7) begin n_miss++; $display("FAIL tone_byte0 got %h want a7", byte_at(0)); end
        n_vec++; if (byte_at(1) !== 8'h3A) begin n_miss++; $display("FAIL tone_byte1 got %h want 3a", byte_at(1)); end
        n_vec++; if (ack_log.size() != 1 || ack_at(0) != 1) begin
            n_miss++; $display("FAIL tone_acks got n=%0d first=%0d want n=1 first=1", ack_log.size(), ack_at(0));
        end
        n_vec++; if (d_glitch != 0) begin n_miss++; $display("FAIL tone_dstable got %0d changes want 0", d_glitch); end
        $display("test_tone: req1 sel=010 data=3a7 bytes=%0d", byte_log.size());
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        rdy_stuck = 1'b1;
        set_req(0, 3'b010, 10'h3A7);
        wait_ack(0, 6000, ok);
        req[0] = 1'b0;
        rdy_stuck = 1'b0;
        repeat (10) @(negedge CLK100MHZ);
        n_vec++; if (!ok) begin n_miss++; $display("FAIL to_ack got none want ack0"); end
        n_vec++; if (last_low_len != 4096) begin n_miss++; $display("FAIL to_len got %0d want 4096", last_low_len); end
        n_vec++; if (byte_log.size() != 1) begin n_miss++; $display("FAIL to_nbytes got %0d want 1", byte_log.size()); end
        n_vec++; if (byte_at(0) !== 8'hA7) begin n_miss++; $display("FAIL to_byte got %h want a7", byte_at(0)); end
        n_vec++; if (timeout_err !== 1'b1) begin n_miss++; $display("FAIL to_err got %b want 1", timeout_err); end
        err_clr = 1'b1;
        @(negedge CLK100MHZ);
        err_clr = 1'b0;
        n_vec++; if (timeout_err !== 1'b0) begin n_miss++; $display("FAIL to_clr got %b want 0", timeout_err); end
        $display("test_timeout: strobe low %0d cycles, err cleared", last_low_len);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [8] = '{8'h83, 8'h12, 8'hC5, 8'h2C, 8'h83, 8'h12, 8'hC5, 8'h2C};
        int exp_a [4] = '{0, 1, 0, 1};
        int n_acks = 0;
        CPU_RESETN = 1'b0;
        @(negedge CLK100MHZ);
        clear_logs();
        set_req(0, 3'b000, 10'h123);
        set_req(1, 3'b100, 10'h2C5);
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        for (int i = 0; i < 2000 && n_acks < 4; i++) begin
            @(negedge CLK100MHZ);
            if (|ack) n_acks++;
        end
        req = 2'b00;
        repeat (60) @(negedge CLK100MHZ);
        n_vec++; if (n_acks != 4) begin n_miss++; $display("FAIL b2b_budget got %0d acks want 4", n_acks); end
        n_vec++; if (byte_log.size() != 8) begin n_miss++; $display("FAIL b2b_nbytes got %0d want 8", byte_log.size()); end
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (byte_at(i) !== exp_b[i]) begin
                n_miss++; $display("FAIL b2b_byte%0d got %h want %h", i, byte_at(i), exp_b[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ack_at(i) != exp_a[i]) begin
                n_miss++; $display("FAIL b2b_grant%0d got %0d want %0d", i, ack_at(i), exp_a[i]);
            end
        end
        $display("test_back_to_back: %0d acks, %0d bytes", ack_log.size(), byte_log.size());
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        clear_logs();
        rdy_low = 40;
        set_req(0, 3'b010, 10'h3A7);
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK100MHZ);
            if (!READY && !nCE) begin seen = 1'b1; break; end
        end
        n_vec++; if (!seen) begin n_miss++; $display("FAIL rm_reach got no READY low want WAITRDY"); end
        @(negedge CLK100MHZ);
        CPU_RESETN = 1'b0;
        req[0] = 1'b0;
        #1;
        n_vec++; if (nCE !== 1'b1) begin n_miss++; $display("FAIL rm_nCE got %b want 1", nCE); end
        n_vec++; if (nWE !== 1'b1) begin n_miss++; $display("FAIL rm_nWE got %b want 1", nWE); end
        n_vec++; if (D !== 8'h00)  begin n_miss++; $display("FAIL rm_D got %h want 00", D); end
        repeat (2) @(negedge CLK100MHZ);
        CPU_RESETN = 1'b1;
        rdy_low = 6;
        repeat (100) @(negedge CLK100MHZ);
        n_vec++; if (ack_log.size() != 0) begin n_miss++; $display("FAIL rm_noack got %0d acks want 0", ack_log.size()); end
        clear_logs();
        set_req(0, 3'b010, 10'h3A7);
        wait_ack(0, 500, ok);
        req[0] = 1'b0;
        repeat (10) @(negedge CLK100MHZ);
        n_vec++; if (!ok) begin n_miss++; $display("FAIL rm_reissue got none want ack0"); end
        n_vec++; if (byte_at(0) !== 8'hA7 || byte_at(1) !== 8'h3A || byte_log.size() != 2) begin
            n_miss++; $display("FAIL rm_bytes got n=%0d %h %h want n=2 a7 3a", byte_log.size(), byte_at(0), byte_at(1));
        end
        $display("test_reset_mid: aborted write dropped, reissue bytes=%0d", byte_log.size());
    endtask

    task automatic test_divider_period();
        n_vec++; if (pulse_cnt < 10) begin n_miss++; $display("FAIL div_count got %0d pulses want >=10", pulse_cnt); end
        n_vec++; if (bad_int != 0) begin n_miss++; $display("FAIL div_period got %0d bad intervals want 0", bad_int); end
        $display("test_divider_period: %0d pulses observed", pulse_cnt);
    endtask

    initial begin
        test_reset();
        test_divider();
        test_volume();
        test_noise();
        test_tone();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_divider_period();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
